// File: rtl/mr_wb_sched_pkg.sv
// rtl/mr_wb_sched_pkg.sv - shared types for the execute-side write-back path
package mr_wb_sched_pkg;

  // Which execute unit owns the write-back slot of an issued instruction.
  typedef enum logic {
    WBSRC_ALU = 1'b0,
    WBSRC_LSU = 1'b1
  } e_wb_src;

endpackage

// File: rtl/mr_order_fifo.sv
// rtl/mr_order_fifo.sv - generic synchronous circular FIFO, no read/write bypass
module mr_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Guard locally so an illegal request can never corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mr_wb_sched.sv
// rtl/mr_wb_sched.sv - in-order write-back scheduler; grants the regfile port
// only to the unit whose tag is at the head of the issue-order queue
module mr_wb_sched
  import mr_wb_sched_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_src,
  output logic                   issue_ready,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [REGSEL_BITS-1:0] alu_wb_reg,
  input  logic [XLEN-1:0]        alu_wb_val,
  input  logic                   lsu_wb_valid,
  output logic                   lsu_wb_ready,
  input  logic [REGSEL_BITS-1:0] lsu_wb_reg,
  input  logic [XLEN-1:0]        lsu_wb_val,
  output logic                   wb_valid,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic [XLEN-1:0]        wb_val,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   order_err
);

  localparam logic [$clog2(DEPTH):0] DEPTH_C = ($clog2(DEPTH)+1)'(DEPTH);

  logic [0:0]             fifo_dout;
  logic                   fifo_full, fifo_empty;
  logic                   fifo_push, fifo_pop;
  e_wb_src                head;
  logic                   alu_acc, lsu_acc;

  logic                   wb_valid_q, wb_valid_d;
  logic [REGSEL_BITS-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]        wb_val_q, wb_val_d;
  logic                   order_err_q, order_err_d;

  mr_order_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (issue_src),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  assign head         = e_wb_src'(fifo_dout);
  assign issue_ready  = rst_n & ~fifo_full;
  assign alu_wb_ready = rst_n & ~fifo_empty & (head == WBSRC_ALU);
  assign lsu_wb_ready = rst_n & ~fifo_empty & (head == WBSRC_LSU);
  assign alu_acc      = alu_wb_valid & alu_wb_ready;
  assign lsu_acc      = lsu_wb_valid & lsu_wb_ready;
  assign fifo_push    = issue_valid & issue_ready;
  assign fifo_pop     = alu_acc | lsu_acc;

  always_comb begin
    wb_valid_d  = alu_acc | lsu_acc;
    wb_reg_d    = wb_reg_q;
    wb_val_d    = wb_val_q;
    order_err_d = order_err_q;
    if (alu_acc) begin
      wb_reg_d = alu_wb_reg;
      wb_val_d = alu_wb_val;
    end else if (lsu_acc) begin
      wb_reg_d = lsu_wb_reg;
      wb_val_d = lsu_wb_val;
    end
    // A result with no matching tag, or a push into a full queue, means
    // decode and execute have lost track of each other.
    if (((alu_wb_valid | lsu_wb_valid) & fifo_empty) | (issue_valid & ~issue_ready)) begin
      order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_val_q    <= '0;
      order_err_q <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_reg_q    <= wb_reg_d;
      wb_val_q    <= wb_val_d;
      order_err_q <= order_err_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_reg    = wb_reg_q;
  assign wb_val    = wb_val_q;
  assign order_err = order_err_q;

  a_one_grant: assert property (@(posedge clk) !(alu_wb_ready && lsu_wb_ready));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= DEPTH_C);

endmodule

// File: tb/tb_mr_wb_sched.sv
// tb/tb_mr_wb_sched.sv - directed table-driven bench for mr_wb_sched
module tb_mr_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_src, issue_ready;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_reg;
  logic [31:0] alu_wb_val;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_reg;
  logic [31:0] lsu_wb_val;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;
  logic [2:0]  outstanding;
  logic        order_err;

  always #5 clk = ~clk;

  mr_wb_sched #(.XLEN(32), .REGSEL_BITS(5), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_src    (issue_src),
    .issue_ready  (issue_ready),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_reg   (alu_wb_reg),
    .alu_wb_val   (alu_wb_val),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_reg   (lsu_wb_reg),
    .lsu_wb_val   (lsu_wb_val),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_val       (wb_val),
    .outstanding  (outstanding),
    .order_err    (order_err)
  );

  typedef struct {
    logic        rst_n, iv, isrc, av;
    logic [4:0]  areg;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  lreg;
    logic [31:0] lval;
    logic        e_ir, e_ar, e_lr, e_wv;
    logic [4:0]  e_wreg;
    logic [31:0] e_wval;
    logic [2:0]  e_out;
    logic        e_err;
    logic        cd;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input int which, input logic r, input logic iv, input logic isrc,
                     input logic av, input logic [4:0] areg, input logic [31:0] aval,
                     input logic lv, input logic [4:0] lreg, input logic [31:0] lval,
                     input logic ir, input logic ar, input logic lr, input logic wv,
                     input logic [4:0] wreg, input logic [31:0] wval, input logic [2:0] out,
                     input logic err, input logic cd);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.isrc = isrc; v.av = av; v.areg = areg; v.aval = aval;
    v.lv = lv; v.lreg = lreg; v.lval = lval; v.e_ir = ir; v.e_ar = ar; v.e_lr = lr;
    v.e_wv = wv; v.e_wreg = wreg; v.e_wval = wval; v.e_out = out; v.e_err = err; v.cd = cd;
    if (which == 0) tbl_a.push_back(v);
    else tbl_b.push_back(v);
  endtask

  task automatic drive(input logic r, input logic iv, input logic isrc, input logic av,
                       input logic [4:0] areg, input logic [31:0] aval, input logic lv,
                       input logic [4:0] lreg, input logic [31:0] lval);
    rst_n = r; issue_valid = iv; issue_src = isrc;
    alu_wb_valid = av; alu_wb_reg = areg; alu_wb_val = aval;
    lsu_wb_valid = lv; lsu_wb_reg = lreg; lsu_wb_val = lval;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int row);
    @(negedge clk);
    drive(v.rst_n, v.iv, v.isrc, v.av, v.areg, v.aval, v.lv, v.lreg, v.lval);
    #1;
    chk($sformatf("%s[%0d].issue_ready", tag, row), 32'(issue_ready), 32'(v.e_ir));
    chk($sformatf("%s[%0d].alu_wb_ready", tag, row), 32'(alu_wb_ready), 32'(v.e_ar));
    chk($sformatf("%s[%0d].lsu_wb_ready", tag, row), 32'(lsu_wb_ready), 32'(v.e_lr));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d].wb_valid", tag, row), 32'(wb_valid), 32'(v.e_wv));
    chk($sformatf("%s[%0d].outstanding", tag, row), 32'(outstanding), 32'(v.e_out));
    chk($sformatf("%s[%0d].order_err", tag, row), 32'(order_err), 32'(v.e_err));
    if (v.cd) begin
      chk($sformatf("%s[%0d].wb_reg", tag, row), 32'(wb_reg), 32'(v.e_wreg));
      chk($sformatf("%s[%0d].wb_val", tag, row), wb_val, v.e_wval);
    end
  endtask

  initial begin
    int pat[10] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    logic mq[$];
    logic head;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset with every input high, then release idle
    add(0, 0, 1, 1, 1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 0, 1);
    add(0, 0, 1, 1, 1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 0, 1);
    add(0, 1, 0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0, 32'h0, 3'd0, 0, 1);
    // Ordering: ALU then LSU tag; LSU result shows up first but must wait
    add(0, 1, 1, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd0, 32'h0,  3'd1, 0, 1);
    add(0, 1, 1, 1, 0, 5'd0,  32'h0,   1, 5'd5, 32'hAA, 1, 1, 0, 0, 5'd0, 32'h0,  3'd2, 0, 1);
    add(0, 1, 0, 0, 1, 5'd5,  32'h11,  1, 5'd5, 32'hAA, 1, 1, 0, 1, 5'd5, 32'h11, 3'd1, 0, 1);
    add(0, 1, 0, 0, 0, 5'd0,  32'h0,   1, 5'd5, 32'hAA, 1, 0, 1, 1, 5'd5, 32'hAA, 3'd0, 0, 1);
    add(0, 1, 0, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd5, 32'hAA, 3'd0, 0, 1);
    // Fill to DEPTH, hold full, retire one
    add(0, 1, 1, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd5, 32'hAA, 3'd1, 0, 1);
    add(0, 1, 1, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 1, 0, 0, 5'd5, 32'hAA, 3'd2, 0, 1);
    add(0, 1, 1, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 1, 0, 0, 5'd5, 32'hAA, 3'd3, 0, 1);
    add(0, 1, 1, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  1, 1, 0, 0, 5'd5, 32'hAA, 3'd4, 0, 1);
    add(0, 1, 0, 0, 0, 5'd0,  32'h0,   0, 5'd0, 32'h0,  0, 1, 0, 0, 5'd5, 32'hAA, 3'd4, 0, 1);
    add(0, 1, 0, 0, 1, 5'd1,  32'h100, 0, 5'd0, 32'h0,  0, 1, 0, 1, 5'd1, 32'h100, 3'd3, 0, 1);

    // Refill to full after the wrap run (last wb data depends on that run)
    add(1, 1, 1, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 1, 0, 0, 5'd0,  32'h0,  3'd4, 0, 0);
    // Full queue, push attempt plus pop in the same cycle: push refused
    add(1, 1, 1, 1, 1, 5'd9,  32'h99, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd9,  32'h99, 3'd3, 1, 1);
    add(1, 1, 0, 0, 1, 5'd10, 32'hA0, 0, 5'd0, 32'h0, 1, 1, 0, 1, 5'd10, 32'hA0, 3'd2, 1, 1);
    add(1, 1, 0, 0, 1, 5'd11, 32'hB0, 0, 5'd0, 32'h0, 1, 1, 0, 1, 5'd11, 32'hB0, 3'd1, 1, 1);
    add(1, 1, 0, 0, 1, 5'd12, 32'hC0, 0, 5'd0, 32'h0, 1, 1, 0, 1, 5'd12, 32'hC0, 3'd0, 1, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd12, 32'hC0, 3'd0, 1, 1);
    add(1, 0, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd0,  32'h0,  3'd0, 0, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0,  32'h0,  3'd0, 0, 1);
    // Result on an empty queue
    add(1, 1, 0, 0, 1, 5'd3,  32'h7,  0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0,  32'h0,  3'd0, 1, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0,  32'h0,  3'd0, 1, 1);
    // Mid-operation reset drops queued tags and the in-flight beat
    add(1, 1, 1, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd0, 32'h0,  3'd1, 1, 1);
    add(1, 1, 1, 1, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 1, 0, 0, 5'd0, 32'h0,  3'd2, 1, 1);
    add(1, 1, 1, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 1, 0, 0, 5'd0, 32'h0,  3'd3, 1, 1);
    add(1, 1, 0, 0, 1, 5'd4,  32'h44, 0, 5'd0, 32'h0,  1, 1, 0, 1, 5'd4, 32'h44, 3'd2, 1, 1);
    add(1, 0, 0, 0, 1, 5'd4,  32'h44, 1, 5'd2, 32'h55, 0, 0, 0, 0, 5'd0, 32'h0,  3'd0, 0, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd0, 32'h0,  3'd0, 0, 1);
    add(1, 1, 1, 1, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd0, 32'h0,  3'd1, 0, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  1, 5'd1, 32'h42, 1, 0, 1, 1, 5'd1, 32'h42, 3'd0, 0, 1);
    add(1, 1, 0, 0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  1, 0, 0, 0, 5'd1, 32'h42, 3'd0, 0, 1);

    foreach (tbl_a[i]) run_vec(tbl_a[i], "a", i);

    // Push and retire every cycle at occupancy 3 across pointer wrap, mixed tags
    mq = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      head = mq[0];
      @(negedge clk);
      drive(1'b1, 1'b1, 1'(pat[k]), 1'b1, 5'(k + 1), 32'hA00 + 32'(k),
            1'b1, 5'(k + 17), 32'hB00 + 32'(k));
      #1;
      chk($sformatf("wrap[%0d].issue_ready", k), 32'(issue_ready), 32'd1);
      chk($sformatf("wrap[%0d].alu_wb_ready", k), 32'(alu_wb_ready), 32'(head == 1'b0));
      chk($sformatf("wrap[%0d].lsu_wb_ready", k), 32'(lsu_wb_ready), 32'(head == 1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("wrap[%0d].wb_valid", k), 32'(wb_valid), 32'd1);
      chk($sformatf("wrap[%0d].wb_reg", k), 32'(wb_reg), head ? 32'(k + 17) : 32'(k + 1));
      chk($sformatf("wrap[%0d].wb_val", k), wb_val, head ? 32'hB00 + 32'(k) : 32'hA00 + 32'(k));
      chk($sformatf("wrap[%0d].outstanding", k), 32'(outstanding), 32'd3);
      chk($sformatf("wrap[%0d].order_err", k), 32'(order_err), 32'd0);
      void'(mq.pop_front());
      mq.push_back(1'(pat[k]));
    end

    foreach (tbl_b[i]) run_vec(tbl_b[i], "b", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
